partition_sweep_checker: RTL and testbench
==========================================

// Module: partition_sweep_checker
// PURPOSE
//  - Exhaustive sweep/compare stage around one partition pair (exact vs approximate netlist).
//  - Drives every input vector 0..2^IN_W-1 onto the shared partition inputs and samples both output buses.
//  - Accumulates the error metrics used to score an approximation: mismatching-vector count, total Hamming distance and worst Hamming distance.
//  - Sits upstream of the partitions (feeds pi) and downstream of them (consumes po_exact/po_approx).
// PARAMETERS
//  IN_W    5  partition input width; the sweep covers 2^IN_W vectors
//  OUT_W   7  partition output width
//  SETTLE  1  wait cycles after a vector is applied, before it is sampled (0 allowed)
// PORTS
//  clk        in   1                       rising-edge clock
//  rst        in   1                       synchronous, active-high reset
//  start      in   1                       1-cycle request to begin a sweep
//  pi         out  IN_W                    vector driven to both partitions
//  po_exact   in   OUT_W                   exact partition outputs
//  po_approx  in   OUT_W                   approximate partition outputs
//  busy       out  1                       sweep in progress
//  done       out  1                       results valid; held until the next accepted start
//  err_count  out  IN_W+1                  number of vectors with any output mismatch
//  ham_sum    out  IN_W+$clog2(OUT_W+1)    sum of popcount(po_exact ^ po_approx) over all vectors
//  max_ham    out  $clog2(OUT_W+1)         largest per-vector Hamming distance
// BEHAVIOUR
//  - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  - Reset: state=IDLE. pi, busy, done, err_count, ham_sum, max_ham and the settle counter are all 0.
//  - start is accepted only in IDLE or DONE. On acceptance:
//    - next cycle: pi=0, accumulators cleared, done=0, busy=1;
//    - state goes to SETTLE with count=SETTLE, or to SAMPLE if SETTLE==0.
//  - start is ignored in SETTLE and SAMPLE.
//  - SETTLE: count is decremented each cycle; when count reaches 0, go to SAMPLE. pi is held stable.
//  - SAMPLE (one cycle): d = po_exact ^ po_approx and h = popcount(d).
//    - err_count += (d != 0); ham_sum += h; max_ham = max(max_ham, h).
//    - If pi == all-ones, go to DONE. Otherwise pi increments and the FSM returns to SETTLE (or SAMPLE if SETTLE==0).
//  - Each vector takes SETTLE+1 cycles. done rises exactly 2^IN_W*(SETTLE+1) cycles after the first busy cycle.
//  - DONE: busy=0, done=1. pi holds all-ones. Results are held stable.
//  - Arithmetic is unsigned. Counters are sized so they never overflow: err_count max is 2^IN_W; ham_sum max is 2^IN_W*OUT_W.
//  - pi wrap: pi never wraps back to 0 inside a sweep; the sweep terminates on the all-ones vector.
//  - start and rst in the same cycle: rst wins.
//  - rst mid-sweep: next cycle everything is back at reset values; no partial results remain.
// CONFIGURATION
//  - Macro SWEEP_TRACE_EN:
//    - Defined: adds outputs trace_valid (1), trace_vec (IN_W) and trace_diff (OUT_W).
//      - trace_valid pulses for 1 cycle, the cycle after each SAMPLE.
//      - trace_vec/trace_diff carry that vector and its d. Used for per-vector logging.
//      - All three reset to 0.
//    - Undefined: these ports and their registers do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package sweep_pkg: typedef enum sweep_state_t {IDLE, SETTLE, SAMPLE, DONE}, and a constant function for the width of a popcount result.
//  - Sub-module sweep_popcount (OUT_W-bit combinational popcount) instantiated once. Everything else lives in this module.
// TESTING (IN_W=5, OUT_W=7, SETTLE=1)
//  1. po_approx tied to po_exact, one start pulse
//     -> done=1 64 cycles after busy rises; err_count=0, ham_sum=0, max_ham=0.
//  2. po_approx = po_exact ^ 7'b0000001 for all vectors
//     -> err_count=32, ham_sum=32, max_ham=1.
//  3. Approx differs only at pi=5'b11111, by 7'b1111111
//     -> err_count=1, ham_sum=7, max_ham=7; pi holds 5'b11111 in DONE.
//  4. start pulsed during busy at pi=3: ignored; results match scenario 2.
//     Then start in DONE -> done drops, accumulators clear, and the second sweep gives identical results.
//  5. rst asserted when pi=10 -> next cycle pi=0, busy=0, done=0, all metrics 0.
//     A new start gives the full, correct results.
//  6. With SWEEP_TRACE_EN and scenario 2 stimulus
//     -> exactly 32 trace_valid pulses, trace_vec 0..31 in order, trace_diff=7'b0000001 on every pulse.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and helpers for the partition sweep checker.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Bits needed to hold a popcount of a w-bit word (0..w).
    function automatic int pc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sweep_popcount.sv
// Combinational population count of a W-bit word.
module sweep_popcount #(
    parameter int W   = 7,
    localparam int PW = sweep_pkg::pc_width(W)
) (
    input  logic [W-1:0]  word_i,
    output logic [PW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + PW'(word_i[i]);
        end
    end

endmodule

// File: rtl/partition_sweep_checker.sv
// Exhaustive sweep/compare of an exact vs approximate partition pair, accumulating error metrics.
// Optional macro SWEEP_TRACE_EN adds per-vector trace outputs (trace_valid, trace_vec, trace_diff).
module partition_sweep_checker #(
    parameter int IN_W   = 5,
    parameter int OUT_W  = 7,
    parameter int SETTLE = 1,
    localparam int PW    = sweep_pkg::pc_width(OUT_W),
    localparam int HSW   = IN_W + PW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [IN_W-1:0]        pi,
    input  logic [OUT_W-1:0]       po_exact,
    input  logic [OUT_W-1:0]       po_approx,
    output logic                   busy,
    output logic                   done,
    output logic [IN_W:0]          err_count,
    output logic [HSW-1:0]         ham_sum,
    output logic [PW-1:0]          max_ham,
`ifdef SWEEP_TRACE_EN
    output logic                   trace_valid,
    output logic [IN_W-1:0]        trace_vec,
    output logic [OUT_W-1:0]       trace_diff,
`endif
    output sweep_pkg::sweep_state_t dbg_state_o
);
    import sweep_pkg::*;

    localparam int EW    = IN_W + 1;
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE);
    localparam logic [IN_W-1:0]  PI_LAST  = '1;

    // Handshake: start is a one-cycle request honoured only in IDLE or DONE;
    // done then stays high with stable results until the next accepted start.
    sweep_state_t     state_q, state_d, first_st;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  pi_q, pi_d;
    logic [EW-1:0]    err_q, err_d;
    logic [HSW-1:0]   ham_q, ham_d;
    logic [PW-1:0]    max_q, max_d;
    logic [OUT_W-1:0] diff;
    logic [PW-1:0]    h;

    assign diff = po_exact ^ po_approx;

    sweep_popcount #(.W(OUT_W)) u_popcount (
        .word_i  (diff),
        .count_o (h)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pi_d     = pi_q;
        err_d    = err_q;
        ham_d    = ham_q;
        max_d    = max_q;
        first_st = sweep_pkg::SETTLE;
        if (SETTLE == 0) first_st = SAMPLE;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = first_st;
                    cnt_d   = CNT_INIT;
                    pi_d    = '0;
                    err_d   = '0;
                    ham_d   = '0;
                    max_d   = '0;
                end
            end
            sweep_pkg::SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) state_d = SAMPLE;
            end
            SAMPLE: begin
                err_d = err_q + EW'(diff != '0);
                ham_d = ham_q + HSW'(h);
                if (h > max_q) max_d = h;
                // The sweep ends on the all-ones vector, so pi never wraps.
                if (pi_q == PI_LAST) begin
                    state_d = DONE;
                end else begin
                    pi_d    = pi_q + IN_W'(1);
                    cnt_d   = CNT_INIT;
                    state_d = first_st;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pi_q    <= '0;
            err_q   <= '0;
            ham_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pi_q    <= pi_d;
            err_q   <= err_d;
            ham_q   <= ham_d;
            max_q   <= max_d;
        end
    end

    assign pi          = pi_q;
    assign busy        = (state_q == sweep_pkg::SETTLE) || (state_q == SAMPLE);
    assign done        = (state_q == DONE);
    assign err_count   = err_q;
    assign ham_sum     = ham_q;
    assign max_ham     = max_q;
    assign dbg_state_o = state_q;

`ifdef SWEEP_TRACE_EN
    logic             trace_valid_q;
    logic [IN_W-1:0]  trace_vec_q;
    logic [OUT_W-1:0] trace_diff_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid_q <= 1'b0;
            trace_vec_q   <= '0;
            trace_diff_q  <= '0;
        end else begin
            trace_valid_q <= (state_q == SAMPLE);
            if (state_q == SAMPLE) begin
                trace_vec_q  <= pi_q;
                trace_diff_q <= diff;
            end
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_vec   = trace_vec_q;
    assign trace_diff  = trace_diff_q;
`endif

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Directed-plus-random bench for partition_sweep_checker against a table-driven reference model.
module tb_partition_sweep_checker;

    localparam int IN_W   = 5;
    localparam int OUT_W  = 7;
    localparam int SETTLE = 1;
    localparam int NV     = 1 << IN_W;
    localparam int PW     = 3;
    localparam int HSW    = IN_W + PW;
    localparam int SWEEP_CYCLES = NV * (SETTLE + 1);

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic [IN_W-1:0]         pi;
    logic [OUT_W-1:0]        po_exact;
    logic [OUT_W-1:0]        po_approx;
    logic                    busy;
    logic                    done;
    logic [IN_W:0]           err_count;
    logic [HSW-1:0]          ham_sum;
    logic [PW-1:0]           max_ham;
    sweep_pkg::sweep_state_t dbg_state;
`ifdef SWEEP_TRACE_EN
    logic                    trace_valid;
    logic [IN_W-1:0]         trace_vec;
    logic [OUT_W-1:0]        trace_diff;
`endif

    // Partition models: exact output table and per-vector error mask.
    logic [OUT_W-1:0] exact_tab [NV];
    logic [OUT_W-1:0] mask_tab  [NV];
    logic [IN_W-1:0]  exp_q[$];

    int checks = 0;
    int errors = 0;

    always_comb begin
        po_exact  = exact_tab[pi];
        po_approx = exact_tab[pi] ^ mask_tab[pi];
    end

    partition_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pi          (pi),
        .po_exact    (po_exact),
        .po_approx   (po_approx),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .ham_sum     (ham_sum),
        .max_ham     (max_ham),
`ifdef SWEEP_TRACE_EN
        .trace_valid (trace_valid),
        .trace_vec   (trace_vec),
        .trace_diff  (trace_diff),
`endif
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: metrics follow directly from the error masks.
    task automatic model(output int e, output int hs, output int mh);
        e = 0; hs = 0; mh = 0;
        for (int v = 0; v < NV; v++) begin
            int hv;
            hv = $countones(mask_tab[v]);
            if (hv != 0) e++;
            hs += hv;
            if (hv > mh) mh = hv;
        end
    endtask

    task automatic fill_exact();
        for (int v = 0; v < NV; v++) exact_tab[v] = OUT_W'($urandom_range(0, 127));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pi"},   32'(pi), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"},  32'(err_count), 0);
        check({tag, "_ham"},  32'(ham_sum), 0);
        check({tag, "_max"},  32'(max_ham), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(sweep_pkg::IDLE));
`ifdef SWEEP_TRACE_EN
        check({tag, "_tvalid"}, 32'(trace_valid), 0);
`endif
    endtask

    // Driver + scoreboard for one full sweep; inject >= 0 pulses start mid-sweep at that pi.
    task automatic run_sweep(input string tag, input int inject);
        int n, e, hs, mh;
        bit injected;
        model(e, hs, mh);
        exp_q.delete();
        for (int v = 0; v < NV; v++) exp_q.push_back(IN_W'(v));
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_pi"},   32'(pi), 0);
        check({tag, "_start_busy"}, 32'(busy), 1);
        check({tag, "_start_done"}, 32'(done), 0);
        check({tag, "_start_err"},  32'(err_count), 0);
        check({tag, "_start_ham"},  32'(ham_sum), 0);
        check({tag, "_start_max"},  32'(max_ham), 0);
        n = 0;
        injected = 1'b0;
        while (done !== 1'b1 && n < 4 * SWEEP_CYCLES) begin
            if (inject >= 0 && !injected && pi == IN_W'(inject)) begin
                start = 1'b1;
                injected = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
`ifdef SWEEP_TRACE_EN
            if (trace_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_trace_extra"}, 32'(trace_valid), 0);
                end else begin
                    logic [IN_W-1:0] v;
                    v = exp_q.pop_front();
                    check({tag, "_trace_vec"},  32'(trace_vec), 32'(v));
                    check({tag, "_trace_diff"}, 32'(trace_diff), 32'(mask_tab[v]));
                end
            end
`endif
        end
        check({tag, "_cycles"}, n, SWEEP_CYCLES);
`ifdef SWEEP_TRACE_EN
        check({tag, "_trace_left"}, exp_q.size(), 0);
`endif
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_pi"},   32'(pi), NV - 1);
        check({tag, "_err"},  32'(err_count), e);
        check({tag, "_ham"},  32'(ham_sum), hs);
        check({tag, "_max"},  32'(max_ham), mh);
        repeat (3) tick();
        check({tag, "_hold_done"}, 32'(done), 1);
        check({tag, "_hold_pi"},   32'(pi), NV - 1);
        check({tag, "_hold_err"},  32'(err_count), e);
        check({tag, "_hold_ham"},  32'(ham_sum), hs);
        check({tag, "_hold_max"},  32'(max_ham), mh);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        for (int v = 0; v < NV; v++) begin
            exact_tab[v] = '0;
            mask_tab[v]  = '0;
        end
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");
        tick();
        check_zero("idle");

        // 1: identical partitions
        fill_exact();
        run_sweep("s1_equal", -1);
        check("s1_err_lit", 32'(err_count), 0);

        // 2: LSB always flipped
        fill_exact();
        for (int v = 0; v < NV; v++) mask_tab[v] = 7'b0000001;
        run_sweep("s2_lsb", -1);
        check("s2_err_lit", 32'(err_count), 32);
        check("s2_ham_lit", 32'(ham_sum), 32);
        check("s2_max_lit", 32'(max_ham), 1);

        // 3: only the last vector differs, in every bit
        fill_exact();
        for (int v = 0; v < NV; v++) mask_tab[v] = '0;
        mask_tab[NV-1] = 7'b1111111;
        run_sweep("s3_last", -1);
        check("s3_err_lit", 32'(err_count), 1);
        check("s3_ham_lit", 32'(ham_sum), 7);
        check("s3_max_lit", 32'(max_ham), 7);

        // 4: start ignored while busy, then restart from DONE
        for (int v = 0; v < NV; v++) mask_tab[v] = 7'b0000001;
        run_sweep("s4_inject", 3);
        run_sweep("s4_again", -1);

        // rst and start together: rst wins
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_zero("rst_start");

        // 5: reset mid-sweep at pi=10, then a full random sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (pi !== IN_W'(10) && n < 4 * SWEEP_CYCLES) begin
            tick();
            n++;
        end
        check("s5_reach_pi10", 32'(pi), 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("s5_midrst");
        fill_exact();
        for (int v = 0; v < NV; v++)
            mask_tab[v] = ($urandom_range(0, 3) == 0) ? OUT_W'($urandom) : '0;
        run_sweep("s5_rand", -1);

        // Further random error patterns
        for (int r = 0; r < 3; r++) begin
            fill_exact();
            for (int v = 0; v < NV; v++)
                mask_tab[v] = ($urandom_range(0, 1) == 0) ? OUT_W'($urandom) : '0;
            run_sweep("rand", -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
